dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the multi-cycle data-memory responder: FSM states, op encoding, default latency.
package dmem_pkg;

  localparam int DMEM_DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write with enable, asynchronous read by index.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx_i] <= wdata_i;
  end

  assign rdata_o = mem[ridx_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage; stalls the pipeline until each access completes.
// Optional DMEM_POSTED_WRITE_EN adds a one-entry posted store buffer drained through the DRAIN state.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = DMEM_DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef DMEM_POSTED_WRITE_EN
  localparam logic [CW-1:0] LAT_CW = CW'(LATENCY);
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   data_q, data_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic          req_any, req_bad, req_ok;
  logic [IW-1:0] addr_idx;
  logic          stall, ready_now;
  logic          arr_we;
  logic [IW-1:0] arr_widx, arr_ridx;
  logic [31:0]   arr_wdata, arr_rdata;
  logic          unused_addr;

  assign req_any  = MemRead_i | MemWrite_i;
  assign req_bad  = (MemRead_i & MemWrite_i) | (req_any & (addr_i[1:0] != 2'b00));
  assign req_ok   = req_any & ~req_bad;
  // Upper address bits are dropped on purpose: the array aliases modulo its size.
  assign addr_idx    = addr_i[IW+1:2];
  assign unused_addr = ^addr_i[31:IW+2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    wdat_d    = wdat_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    stall     = 1'b0;
    ready_now = 1'b0;
    arr_we    = 1'b0;
    arr_widx  = idx_q;
    arr_wdata = wdat_q;
    arr_ridx  = idx_q;
    case (state_q)
      IDLE: begin
        if (req_bad) begin
          err_d = 1'b1;
        end else if (req_ok) begin
          op_d   = MemWrite_i ? OP_WR : OP_RD;
          idx_d  = addr_idx;
          wdat_d = data_i;
          stall  = 1'b1;
          cnt_d  = LAT_M1;
          if (LATENCY == 1) begin
            // Single-cycle latency: the acceptance edge is also the commit edge.
            state_d   = DONE;
            ready_d   = 1'b1;
            arr_widx  = addr_idx;
            arr_ridx  = addr_idx;
            arr_wdata = data_i;
            arr_we    = MemWrite_i;
            if (MemRead_i) data_d = arr_rdata;
          end else begin
            state_d = BUSY;
          end
`ifdef DMEM_POSTED_WRITE_EN
          if (MemWrite_i) begin
            stall     = 1'b0;
            ready_now = 1'b1;
            ready_d   = 1'b0;
            arr_we    = 1'b0;
            cnt_d     = LAT_CW;
            state_d   = DRAIN;
          end
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          ready_d = 1'b1;
          arr_we  = (op_q == OP_WR);
          if (op_q == OP_RD) data_d = arr_rdata;
        end
      end
      DONE: state_d = IDLE;
`ifdef DMEM_POSTED_WRITE_EN
      DRAIN: begin
        // A new request waits here and is taken by IDLE once the buffer is committed.
        stall = req_any;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          arr_we  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdat_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we & ~rst_i),
    .widx_i  (arr_widx),
    .wdata_i (arr_wdata),
    .ridx_i  (arr_ridx),
    .rdata_o (arr_rdata)
  );

  assign data_o  = data_q;
  assign ready_o = ready_q | (ready_now & ~rst_i);
  assign stall_o = stall & ~rst_i;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 and a LATENCY=1 instance share one request bus.
module tb_dmem_responder;

`ifdef DMEM_POSTED_WRITE_EN
  localparam bit PW = 1'b1;
`else
  localparam bit PW = 1'b0;
`endif

  logic        clk, rst;
  logic        mem_rd, mem_wr, sel1;
  logic [31:0] addr, wdata;
  logic [31:0] d4_data, d1_data;
  logic        d4_rdy, d4_stall, d4_err, d1_rdy, d1_stall, d1_err;
  logic [31:0] o_data;
  logic        o_rdy, o_stall, o_err;
  int checks = 0, failures = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mem_rd & ~sel1), .MemWrite_i(mem_wr & ~sel1),
    .addr_i(addr), .data_i(wdata), .data_o(d4_data), .ready_o(d4_rdy), .stall_o(d4_stall), .err_o(d4_err));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mem_rd & sel1), .MemWrite_i(mem_wr & sel1),
    .addr_i(addr), .data_i(wdata), .data_o(d1_data), .ready_o(d1_rdy), .stall_o(d1_stall), .err_o(d1_err));

  assign o_data  = sel1 ? d1_data  : d4_data;
  assign o_rdy   = sel1 ? d1_rdy   : d4_rdy;
  assign o_stall = sel1 ? d1_stall : d4_stall;
  assign o_err   = sel1 ? d1_err   : d4_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          lat1;
    bit          rd, wr;
    logic [31:0] a, d;
    int          exp_stall, exp_rdy, exp_err;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One pipeline access: inputs held while stall_o is high, dropped once the pipeline advances.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int n_stall, output int rdy_c, output int err_c, output logic [31:0] dout);
    bit released = 1'b0;
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
    n_stall = 0; rdy_c = -1; err_c = -1; dout = 32'h0;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (o_stall) n_stall++;
      if (o_rdy && rdy_c < 0) begin rdy_c = c; dout = o_data; end
      if (o_err && err_c < 0) err_c = c;
      if (!o_stall) released = 1'b1;
      @(negedge clk);
      if (released) begin mem_rd = 1'b0; mem_wr = 1'b0; end
    end
  endtask

  vec_t vecs[$];
  int ns, rc, ec;
  logic [31:0] dv;

  function automatic vec_t mk(string n, bit l1, bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                              int es, int er, int ee, logic [31:0] ed);
    vec_t v;
    v.name = n; v.lat1 = l1; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
    v.exp_stall = es; v.exp_rdy = er; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    // Blocking stores cost LATENCY stall cycles; posted stores complete in the acceptance cycle.
    vecs.push_back(mk("wr_10",        0, 0, 1, 32'h10,  32'hDEADBEEF, PW ? 0 : 4, PW ? 0 : 4, -1, 32'h0));
    vecs.push_back(mk("rd_10",        0, 1, 0, 32'h10,  32'h0,        4, 4, -1, 32'hDEADBEEF));
    vecs.push_back(mk("wr_20",        0, 0, 1, 32'h20,  32'h11112222, PW ? 0 : 4, PW ? 0 : 4, -1, 32'h0));
    vecs.push_back(mk("both_20",      0, 1, 1, 32'h20,  32'hFFFFFFFF, 0, -1, 1, 32'h0));
    vecs.push_back(mk("rd_20_kept",   0, 1, 0, 32'h20,  32'h0,        4, 4, -1, 32'h11112222));
    vecs.push_back(mk("rd_13_misal",  0, 1, 0, 32'h13,  32'h0,        0, -1, 1, 32'h0));
    vecs.push_back(mk("wr_13_misal",  0, 0, 1, 32'h13,  32'h0BAD0BAD, 0, -1, 1, 32'h0));
    vecs.push_back(mk("rd_410_wrap",  0, 1, 0, 32'h410, 32'h0,        4, 4, -1, 32'hDEADBEEF));
    vecs.push_back(mk("wr_3fc_top",   0, 0, 1, 32'h3FC, 32'hA5A5A5A5, PW ? 0 : 4, PW ? 0 : 4, -1, 32'h0));
    vecs.push_back(mk("rd_7fc_wrap",  0, 1, 0, 32'h7FC, 32'h0,        4, 4, -1, 32'hA5A5A5A5));
    vecs.push_back(mk("wr_30_old",    0, 0, 1, 32'h30,  32'hCAFEF00D, PW ? 0 : 4, PW ? 0 : 4, -1, 32'h0));
    vecs.push_back(mk("l1_wr_08",     1, 0, 1, 32'h08,  32'h0BADF00D, PW ? 0 : 1, PW ? 0 : 1, -1, 32'h0));
    vecs.push_back(mk("l1_rd_08",     1, 1, 0, 32'h08,  32'h0,        1, 1, -1, 32'h0BADF00D));
    vecs.push_back(mk("l1_misal",     1, 1, 0, 32'h0A,  32'h0,        0, -1, 1, 32'h0));

    // Reset state, with a request on the bus to show stall_o is masked during reset.
    rst = 1'b1; sel1 = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h10; wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, d4_stall}, 32'h0);
    chk("rst_ready", {31'b0, d4_rdy},   32'h0);
    chk("rst_err",   {31'b0, d4_err},   32'h0);
    chk("rst_data",  d4_data,           32'h0);
    chk("rst_stall_l1", {31'b0, d1_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_rd = 1'b0;

    foreach (vecs[i]) begin
      sel1 = vecs[i].lat1;
      access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, ns, rc, ec, dv);
      chk({vecs[i].name, "_stall"}, ns, vecs[i].exp_stall);
      chk({vecs[i].name, "_ready"}, rc, vecs[i].exp_rdy);
      chk({vecs[i].name, "_err"},   ec, vecs[i].exp_err);
      if (vecs[i].rd && !vecs[i].wr && vecs[i].exp_rdy >= 0)
        chk({vecs[i].name, "_data"}, dv, vecs[i].exp_data);
      // data_o keeps the last load value across the following store.
      if (vecs[i].name == "wr_30_old") chk("data_hold", d4_data, 32'hA5A5A5A5);
    end

    // Reset in cycle 2 of a store to 0x30: the store is discarded.
    sel1 = 1'b0;
    @(negedge clk);
    mem_wr = 1'b1; addr = 32'h30; wdata = 32'h00001234;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {31'b0, d4_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_wr = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, d4_rdy},   32'h0);
    chk("midrst_err",   {31'b0, d4_err},   32'h0);
    chk("midrst_data",  d4_data,           32'h0);
    chk("midrst_stall2", {31'b0, d4_stall}, 32'h0);
    access(1'b1, 1'b0, 32'h30, 32'h0, ns, rc, ec, dv);
    chk("midrst_rd30_ready", rc, 4);
    chk("midrst_rd30_data",  dv, 32'hCAFEF00D);

`ifdef DMEM_POSTED_WRITE_EN
    // Posted store followed immediately by a load of the same word.
    begin
      int st = 0, rdy = -1;
      logic [31:0] got = 32'h0;
      @(negedge clk);
      mem_wr = 1'b1; addr = 32'h40; wdata = 32'h600DCAFE;
      #1;
      chk("pw_store_stall", {31'b0, d4_stall}, 32'h0);
      chk("pw_store_ready", {31'b0, d4_rdy},   32'h1);
      @(negedge clk);
      mem_wr = 1'b0; mem_rd = 1'b1;
      for (int c = 1; c < 14; c++) begin
        #1;
        if (d4_stall) st++;
        if (d4_rdy && rdy < 0) begin rdy = c; got = d4_data; mem_rd = 1'b0; end
        @(negedge clk);
      end
      chk("pw_load_stall", st, 8);
      chk("pw_load_ready", rdy, 9);
      chk("pw_load_data",  got, 32'h600DCAFE);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
